// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_pkg;

    // Controller state: waiting for a fetch, or waiting on a refill word.
    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } cacheState_t;

    // Default log2 of the line count (16 lines of one 32-bit word).
    localparam int INDEX_BITS_DEFAULT = 4;

    // Fetches are word aligned, so the index starts just above the byte offset.
    localparam int INDEX_LSB = 2;

    // The tag starts directly above the index field.
    function automatic int tagLsb(input int indexBits);
        return indexBits + INDEX_LSB;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the icache, one 32-bit word per line.
// Latency: read is combinational; write lands on the next clockIn edge.
// Backpressure: none; the caller qualifies wrEn with its own enable.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic                  clockIn,
    input  logic                  resetIn,
    input  logic [INDEX_BITS-1:0] rdIndex,
    output logic                  rdValid,
    output logic [TAG_BITS-1:0]   rdTag,
    output logic [31:0]           rdData,
    input  logic                  wrEn,
    input  logic [INDEX_BITS-1:0] wrIndex,
    input  logic [TAG_BITS-1:0]   wrTag,
    input  logic [31:0]           wrData
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    validBits;
    logic [TAG_BITS-1:0] tagArray  [LINES];
    logic [31:0]         dataArray [LINES];

    // Valid bits: cleared only by reset, set by a refill of that line.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            validBits <= '0;
        end else if (wrEn) begin
            validBits[wrIndex] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; their contents matter only once valid.
    always_ff @(posedge clockIn) begin
        if (wrEn) begin
            tagArray[wrIndex]  <= wrTag;
            dataArray[wrIndex] <= wrData;
        end
    end

    assign rdValid = validBits[rdIndex];
    assign rdTag   = tagArray[rdIndex];
    assign rdData  = dataArray[rdIndex];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between instruction fetch and MemoryController.
// Latency: hit delivers fetchOk one cycle after acceptance; miss one cycle after memOk.
// Backpressure: fetchFlag is held until fetchOk; readyIn low freezes all state.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEFAULT
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic        clearIn,
    input  logic        fetchFlag,
    input  logic [31:0] fetchAddr,
    output logic        fetchOk,
    output logic [31:0] fetchInst,
    output logic        memFlag,
    output logic [31:0] memAddr,
    input  logic        memOk,
    input  logic [31:0] memData
);

    localparam int TAG_LSB  = tagLsb(INDEX_BITS);
    localparam int TAG_BITS = 32 - TAG_LSB;

    cacheState_t state, stateNext;

    // Latched miss address, word granular (byte offset is always zero).
    logic [31:2] missWord, missWordNext;
    logic        fetchOkNext;
    logic [31:0] fetchInstNext;

    logic                  lineValid;
    logic [TAG_BITS-1:0]   lineTag;
    logic [31:0]           lineData;
    logic                  lineHit;
    logic                  accept;
    logic                  fillEn;
    logic [INDEX_BITS-1:0] fetchIndex;
    logic [TAG_BITS-1:0]   fetchTag;
    logic [INDEX_BITS-1:0] missIndex;
    logic [TAG_BITS-1:0]   missTag;

    // The byte offset of a fetch address carries no information.
    logic unusedAddrBits;
    assign unusedAddrBits = ^fetchAddr[1:0];

    assign fetchIndex = fetchAddr[TAG_LSB-1:INDEX_LSB];
    assign fetchTag   = fetchAddr[31:TAG_LSB];
    assign missIndex  = missWord[TAG_LSB-1:INDEX_LSB];
    assign missTag    = missWord[31:TAG_LSB];

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) lineStore (
        .clockIn (clockIn),
        .resetIn (resetIn),
        .rdIndex (fetchIndex),
        .rdValid (lineValid),
        .rdTag   (lineTag),
        .rdData  (lineData),
        .wrEn    (fillEn),
        .wrIndex (missIndex),
        .wrTag   (missTag),
        .wrData  (memData)
    );

    assign lineHit = lineValid && (lineTag == fetchTag);

    // The delivery cycle never accepts, and a flush cycle accepts nothing.
    assign accept = (state == IDLE) && fetchFlag && !fetchOk && !clearIn;

    // A refill completes even when a flush arrives with it, so the line is usable later.
    assign fillEn = readyIn && !resetIn && (state == MISS) && memOk;

    // Drop the request in the memOk cycle so MemoryController does not start a second fetch.
    assign memFlag = (state == MISS) && !memOk;
    assign memAddr = (state == MISS) ? {missWord, 2'b00} : 32'd0;

    // Next-state and next-output decode.
    always_comb begin
        stateNext     = state;
        missWordNext  = missWord;
        fetchOkNext   = 1'b0;
        fetchInstNext = fetchInst;
        if (clearIn) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (lineHit) begin
                            fetchOkNext   = 1'b1;
                            fetchInstNext = lineData;
                        end else begin
                            missWordNext = fetchAddr[31:2];
                            stateNext    = MISS;
                        end
                    end
                end
                MISS: begin
                    if (memOk) begin
                        fetchOkNext   = 1'b1;
                        fetchInstNext = memData;
                        stateNext     = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // State, miss latch and output registers; frozen while readyIn is low.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state     <= IDLE;
            missWord  <= '0;
            fetchOk   <= 1'b0;
            fetchInst <= 32'd0;
        end else if (readyIn) begin
            state     <= stateNext;
            missWord  <= missWordNext;
            fetchOk   <= fetchOkNext;
            fetchInst <= fetchInstNext;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed fetch sequences with scoreboarded responses.
// Latency: n/a.
// Backpressure: n/a.
module tb_icache;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        readyIn;
    logic        clearIn;
    logic        fetchFlag;
    logic [31:0] fetchAddr;
    logic        fetchOk;
    logic [31:0] fetchInst;
    logic        memFlag;
    logic [31:0] memAddr;
    logic        memOk;
    logic [31:0] memData;

    int total = 0;
    int bad   = 0;

    logic [31:0] instQ[$];
    logic [31:0] memQ[$];
    logic        prevMemFlag = 1'b0;

    icache dut (
        .clockIn   (clockIn),
        .resetIn   (resetIn),
        .readyIn   (readyIn),
        .clearIn   (clearIn),
        .fetchFlag (fetchFlag),
        .fetchAddr (fetchAddr),
        .fetchOk   (fetchOk),
        .fetchInst (fetchInst),
        .memFlag   (memFlag),
        .memAddr   (memAddr),
        .memOk     (memOk),
        .memData   (memData)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every fetchOk pulse and every new memory request is matched to the scoreboard.
    always @(negedge clockIn) begin
        if (fetchOk) begin
            if (instQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_fetchOk: got inst %h want no pulse", fetchInst);
            end else begin
                check("fetchInst", fetchInst, instQ.pop_front());
            end
        end
        if (memFlag && !prevMemFlag) begin
            if (memQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_memFlag: got addr %h want no request", memAddr);
            end else begin
                check("memAddr", memAddr, memQ.pop_front());
            end
        end
        prevMemFlag = memFlag;
    end

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic fetchHit(input logic [31:0] addr, input logic [31:0] inst);
        fetchFlag = 1'b1;
        fetchAddr = addr;
        instQ.push_back(inst);
        tick();
        fetchFlag = 1'b0;
        tick();
    endtask

    task automatic fetchMiss(input logic [31:0] addr, input logic [31:0] data);
        fetchFlag = 1'b1;
        fetchAddr = addr;
        memQ.push_back({addr[31:2], 2'b00});
        tick();
        check("memFlag_in_miss", {31'd0, memFlag}, 32'd1);
        tick();
        memOk   = 1'b1;
        memData = data;
        #1;
        check("memFlag_low_on_memOk", {31'd0, memFlag}, 32'd0);
        instQ.push_back(data);
        tick();
        memOk     = 1'b0;
        fetchFlag = 1'b0;
        tick();
    endtask

    initial begin
        resetIn   = 1'b1;
        readyIn   = 1'b1;
        clearIn   = 1'b0;
        fetchFlag = 1'b0;
        fetchAddr = 32'd0;
        memOk     = 1'b0;
        memData   = 32'd0;
        tick();
        tick();
        resetIn = 1'b0;
        check("reset_fetchOk", {31'd0, fetchOk}, 32'd0);
        check("reset_fetchInst", fetchInst, 32'd0);
        check("reset_memFlag", {31'd0, memFlag}, 32'd0);
        check("reset_memAddr", memAddr, 32'd0);

        // Cold miss, then hit with nonzero byte offset.
        fetchMiss(32'h0000_0000, 32'h0000_0013);
        fetchHit(32'h0000_0002, 32'h0000_0013);

        // Eviction between two tags of index 0.
        fetchMiss(32'h0000_0040, 32'hDEAD_BEEF);
        fetchMiss(32'h0000_0000, 32'h0000_0013);
        fetchMiss(32'h0000_0040, 32'hDEAD_BEEF);
        fetchHit(32'h0000_0040, 32'hDEAD_BEEF);

        // Flush mid-miss, then a stale memOk in IDLE must not write the line.
        fetchFlag = 1'b1;
        fetchAddr = 32'h0000_0100;
        memQ.push_back(32'h0000_0100);
        tick();
        tick();
        clearIn   = 1'b1;
        fetchFlag = 1'b0;
        tick();
        clearIn = 1'b0;
        check("memFlag_after_clear", {31'd0, memFlag}, 32'd0);
        check("memAddr_after_clear", memAddr, 32'd0);
        memOk   = 1'b1;
        memData = 32'h0000_0055;
        tick();
        memOk = 1'b0;
        tick();
        fetchMiss(32'h0000_0100, 32'h1110_0093);

        // Flush coincident with memOk: no delivery, but the line is filled.
        fetchFlag = 1'b1;
        fetchAddr = 32'h0000_0104;
        memQ.push_back(32'h0000_0104);
        tick();
        tick();
        memOk     = 1'b1;
        memData   = 32'h00A0_0093;
        clearIn   = 1'b1;
        fetchFlag = 1'b0;
        tick();
        memOk   = 1'b0;
        clearIn = 1'b0;
        check("memFlag_after_clear_fill", {31'd0, memFlag}, 32'd0);
        tick();
        fetchHit(32'h0000_0104, 32'h00A0_0093);

        // readyIn low freezes acceptance and delivery.
        fetchFlag = 1'b1;
        fetchAddr = 32'h0000_0104;
        readyIn   = 1'b0;
        instQ.push_back(32'h00A0_0093);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fetchOk_frozen", {31'd0, fetchOk}, 32'd0);
        end
        readyIn = 1'b1;
        tick();
        check("fetchOk_after_ready", {31'd0, fetchOk}, 32'd1);
        fetchFlag = 1'b0;
        tick();
        check("fetchOk_one_pulse", {31'd0, fetchOk}, 32'd0);

        // Reset mid-miss kills the request and invalidates every line.
        fetchFlag = 1'b1;
        fetchAddr = 32'h0000_0208;
        memQ.push_back(32'h0000_0208);
        tick();
        tick();
        resetIn   = 1'b1;
        fetchFlag = 1'b0;
        tick();
        resetIn = 1'b0;
        check("memFlag_after_reset", {31'd0, memFlag}, 32'd0);
        check("memAddr_after_reset", memAddr, 32'd0);
        fetchMiss(32'h0000_0104, 32'h0000_0077);
        fetchMiss(32'h0000_0040, 32'h0000_0088);
        fetchHit(32'h0000_0104, 32'h0000_0077);

        tick();
        tick();
        check("instQ_drained", instQ.size(), 32'd0);
        check("memQ_drained", memQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
